mpram_rdw: RTL
==============

// Module: mpram_rdw
// PURPOSE
//  Parametrised multi-port register file, successor to the basic sephirot multi-port RAM.
//  Adds per-byte write enables and deterministic write-conflict priority with a conflict flag.
//  Adds selectable read-during-write bypass, read enables with valid flags, and an optional output register.
//  Adds a post-reset clear engine. Used as the Sephirot lane register file and scratch map store.
// PARAMETERS
//  MEMD      16  number of words (any value >= 2; need not be a power of 2)
//  DATAW     32  word width in bits; must be a multiple of BYTEW
//  BYTEW     8   byte-enable granule width
//  nRPORTS   3   read ports
//  nWPORTS   2   write ports; a higher index has higher priority
//  BYPASS    1   1 = same-cycle write data is forwarded to reads; 0 = reads return old data
//  OREG      0   1 = extra output register stage (read latency 2)
//  INIT_ON_RST 1 1 = clear all words to 0 after reset; 0 = no clear (contents undefined)
// PORTS
//  clk     in   1                    clock, rising edge
//  rst_n   in   1                    asynchronous reset, active low
//  WEnb    in   nWPORTS              write enable per port
//  WBe     in   nWPORTS*DATAW/BYTEW  byte enables, port i at [i*NBE +: NBE]
//  WAddr   in   nWPORTS*ADDRW        write addresses, packed like WBe
//  WData   in   nWPORTS*DATAW        write data
//  REnb    in   nRPORTS              read enable per port
//  RAddr   in   nRPORTS*ADDRW        read addresses
//  RData   out  nRPORTS*DATAW        read data
//  RValid  out  nRPORTS              RData slice valid
//  WConf   out  nWPORTS              port i lost >=1 byte to a higher-priority port
//  Busy    out  1                    clear engine running; all accesses are ignored
// BEHAVIOUR
//  ADDRW = max(1, clog2(MEMD)); NBE = DATAW/BYTEW.
//  Reset values (async, rst_n=0): RData=0, RValid=0, WConf=0.
//   Clear counter = 0; Busy = INIT_ON_RST.
//   The array itself is not reset.
//  Clear FSM CLEAR->READY:
//   CLEAR writes 0 to address cnt on each cycle, cnt = 0..MEMD-1.
//   After the write to MEMD-1, the FSM enters READY and Busy falls at that edge.
//   Total busy time is MEMD cycles after rst_n deasserts.
//   In CLEAR: WEnb/REnb are ignored, RValid stays 0, WConf stays 0.
//   Reset asserted mid-clear restarts the clear at address 0.
//   With INIT_ON_RST=0 the FSM starts in READY.
//  Write (READY):
//   Byte b of word A takes the data of the highest-index port i with WEnb[i], WBe[i][b] and WAddr[i]==A.
//   Bytes with no enable keep their old value.
//   Same address with disjoint bytes merges; no conflict is flagged.
//   WConf[i] is registered, so it is high in the cycle after port i lost any byte. Otherwise it is 0.
//   WAddr >= MEMD: the write is dropped and not counted for conflict.
//  Read (READY):
//   RValid[r] = REnb[r] delayed by 1+OREG cycles.
//   RData[r] updates only when the enable is delayed through the same pipeline. Otherwise it holds.
//   BYPASS=1: when RAddr==A is also written this cycle, return the merged post-write word, byte-accurate.
//   BYPASS=0: return the pre-write word.
//   RAddr >= MEMD returns 0 with RValid=1.
//   Enabled read ports are fully independent and may share an address.
// STRUCTURE
//  mpram_defs.vh: ADDRW/NBE computation (uses clog2_function.vh), clear-FSM state encodings.
//  Sub-module mpram_wmerge (combinational): inputs are the old word, all write ports and an address.
//   Outputs are the per-byte priority-merged word, the hit flag and per-port loss bits.
//   One instance per word for write commit. One per read port for the bypass path (BYPASS=1).
//  Top: clear FSM, array, read pipeline (1 or 2 stages), WConf register.
// TESTING
//  Clear: rst_n low 3 cycles then high.
//   -> Busy=1 for exactly 16 cycles.
//   -> A read of every address afterwards returns 0.
//   -> A write attempted while Busy is not applied.
//  Byte merge: P0 writes A=5, WBe=0011, D=0x1111_2222; P1 writes A=5, WBe=1100, D=0x3333_4444, same cycle.
//   -> mem[5]=0x3333_2222, WConf=00.
//  Conflict: P0 and P1 write A=7 with WBe=1111, D0=0xAAAA_AAAA, D1=0x5555_5555.
//   -> mem[7]=0x5555_5555, WConf=01 next cycle only.
//  Bypass: mem[3]=0x0; write A=3, D=0xDEAD_BEEF with a same-cycle read of A=3.
//   -> BYPASS=1: RData=0xDEAD_BEEF.
//   -> BYPASS=0: RData=0, then the next read returns 0xDEAD_BEEF.
//  Latency/hold: OREG=1, REnb pulsed 1 cycle on A=2 (0x1234).
//   -> RValid high exactly 2 cycles later, for 1 cycle.
//   -> RData stays 0x1234 afterwards while REnb=0.
//  Bounds/reset: MEMD=12, write A=13 is dropped and a read of A=13 returns 0.
//   rst_n pulsed mid-clear at cnt=6 -> Busy lasts 12 more cycles.

Source files
------------

// File: rtl/mpram_rdw_pkg.sv
// Shared definitions for the mpram_rdw multi-port register file.
//  - clr_state_e : post-reset clear engine states
//  - addr_width  : address width for a given depth, never less than 1 bit
package mpram_rdw_pkg;

   typedef enum logic {
      StClear = 1'b0,
      StReady = 1'b1
   } clr_state_e;

   function automatic int unsigned addr_width(input int unsigned memd);
      return (memd <= 2) ? 1 : $clog2(memd);
   endfunction

endpackage

// File: rtl/mpram_rdw_wmerge.sv
// Combinational byte-wise priority merge of all write ports onto one word.
// Ports:
//  old_word  in   DATAW       current contents of the word
//  wenb      in   NWP         write enables (already gated by the caller)
//  wbe       in   NWP*NBE     byte enables, port i at [i*NBE +: NBE]
//  waddr     in   NWP*ADDRW   write addresses
//  wdata     in   NWP*DATAW   write data
//  addr      in   ADDRW       address of the word being merged
//  new_word  out  DATAW       merged word (old bytes kept where nobody writes)
//  hit       out  1           at least one byte written
//  loss      out  NWP         port i had a byte overridden by a higher port
module mpram_rdw_wmerge
   import mpram_rdw_pkg::*;
#(
   parameter int unsigned DATAW = 32,
   parameter int unsigned BYTEW = 8,
   parameter int unsigned NWP   = 2,
   parameter int unsigned ADDRW = 4
) (
   input  logic [DATAW-1:0]               old_word,
   input  logic [NWP-1:0]                 wenb,
   input  logic [NWP*(DATAW/BYTEW)-1:0]   wbe,
   input  logic [NWP*ADDRW-1:0]           waddr,
   input  logic [NWP*DATAW-1:0]           wdata,
   input  logic [ADDRW-1:0]               addr,
   output logic [DATAW-1:0]               new_word,
   output logic                           hit,
   output logic [NWP-1:0]                 loss
);

   localparam int unsigned NBE = DATAW / BYTEW;

   logic [NWP-1:0][NBE-1:0] sel;
   logic                    taken;

   always_comb begin
      for (int i = 0; i < NWP; i++) begin
         for (int b = 0; b < NBE; b++) begin
            sel[i][b] = wenb[i] & wbe[i*NBE + b] & (waddr[i*ADDRW +: ADDRW] == addr);
         end
      end
   end

   // Walk ports from highest to lowest: the first selected port owns the
   // byte, every later selected port has lost it.
   always_comb begin
      new_word = old_word;
      hit      = 1'b0;
      loss     = '0;
      taken    = 1'b0;
      for (int b = 0; b < NBE; b++) begin
         taken = 1'b0;
         for (int i = NWP - 1; i >= 0; i--) begin
            if (sel[i][b]) begin
               if (taken) begin
                  loss[i] = 1'b1;
               end else begin
                  new_word[b*BYTEW +: BYTEW] = wdata[i*DATAW + b*BYTEW +: BYTEW];
                  taken = 1'b1;
               end
            end
         end
         hit = hit | taken;
      end
   end

endmodule

// File: rtl/mpram_rdw.sv
// Multi-port register file with byte enables, write priority, optional
// read-during-write bypass, optional output register and post-reset clear.
// Ports:
//  clk, rst_n  clock (rising edge), asynchronous active-low reset
//  WEnb/WBe/WAddr/WData  write ports, higher index wins on shared bytes
//  REnb/RAddr            read ports
//  RData/RValid          read data and valid, latency 1+OREG
//  WConf                 registered per-port "lost a byte" flag
//  Busy                  clear engine running, all accesses ignored
module mpram_rdw
   import mpram_rdw_pkg::*;
#(
   parameter int unsigned MEMD        = 16,
   parameter int unsigned DATAW       = 32,
   parameter int unsigned BYTEW       = 8,
   parameter int unsigned nRPORTS     = 3,
   parameter int unsigned nWPORTS     = 2,
   parameter int unsigned BYPASS      = 1,
   parameter int unsigned OREG        = 0,
   parameter int unsigned INIT_ON_RST = 1,
   localparam int unsigned ADDRW      = addr_width(MEMD),
   localparam int unsigned NBE        = DATAW / BYTEW
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [nWPORTS-1:0]         WEnb,
   input  logic [nWPORTS*NBE-1:0]     WBe,
   input  logic [nWPORTS*ADDRW-1:0]   WAddr,
   input  logic [nWPORTS*DATAW-1:0]   WData,
   input  logic [nRPORTS-1:0]         REnb,
   input  logic [nRPORTS*ADDRW-1:0]   RAddr,
   output logic [nRPORTS*DATAW-1:0]   RData,
   output logic [nRPORTS-1:0]         RValid,
   output logic [nWPORTS-1:0]         WConf,
   output logic                       Busy
);

   clr_state_e        state_q, state_d;
   logic [ADDRW-1:0]  cnt_q, cnt_d;
   logic              ready;
   logic [DATAW-1:0]  mem_q [MEMD];

   assign ready = (state_q == StReady);
   assign Busy  = ~ready;

   // Clear engine
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StClear: begin
            if (32'(cnt_q) == MEMD - 1) begin
               state_d = StReady;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StReady: state_d = StReady;
         default: state_d = StReady;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= (INIT_ON_RST != 0) ? StClear : StReady;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Writes and reads are simply masked while the clear engine runs
   logic [nWPORTS-1:0] wenb_g;
   logic [nRPORTS-1:0] renb_g;
   assign wenb_g = ready ? WEnb : '0;
   assign renb_g = ready ? REnb : '0;

   // Write commit: one merge per word. Words outside 0..MEMD-1 have no
   // instance, so out-of-range writes never hit and never count as conflicts.
   logic [DATAW-1:0]   commit_word [MEMD];
   logic [MEMD-1:0]    commit_hit;
   logic [nWPORTS-1:0] commit_loss [MEMD];

   for (genvar a = 0; a < MEMD; a++) begin : g_word
      mpram_rdw_wmerge #(
         .DATAW (DATAW),
         .BYTEW (BYTEW),
         .NWP   (nWPORTS),
         .ADDRW (ADDRW)
      ) u_wmerge (
         .old_word (mem_q[a]),
         .wenb     (wenb_g),
         .wbe      (WBe),
         .waddr    (WAddr),
         .wdata    (WData),
         .addr     (ADDRW'(a)),
         .new_word (commit_word[a]),
         .hit      (commit_hit[a]),
         .loss     (commit_loss[a])
      );
   end

   always_ff @(posedge clk) begin
      for (int a = 0; a < MEMD; a++) begin
         if (!ready && (cnt_q == ADDRW'(a))) begin
            mem_q[a] <= '0;
         end else if (commit_hit[a]) begin
            mem_q[a] <= commit_word[a];
         end
      end
   end

   logic [nWPORTS-1:0] wconf_d, wconf_q;

   always_comb begin
      wconf_d = '0;
      for (int a = 0; a < MEMD; a++) begin
         wconf_d = wconf_d | commit_loss[a];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wconf_q <= '0;
      else        wconf_q <= wconf_d;
   end

   assign WConf = wconf_q;

   // Read path: stage-1 word per port, bypassed through a merge if enabled
   logic [nRPORTS-1:0][DATAW-1:0] rd_word;

   for (genvar r = 0; r < nRPORTS; r++) begin : g_rd
      logic [ADDRW-1:0] ra;
      logic             in_range;
      logic [DATAW-1:0] old_word;

      assign ra       = RAddr[r*ADDRW +: ADDRW];
      assign in_range = (32'(ra) < MEMD);
      assign old_word = in_range ? mem_q[ra] : '0;

      if (BYPASS != 0) begin : g_byp
         logic [DATAW-1:0]   merged;
         logic               unused_hit;
         logic [nWPORTS-1:0] unused_loss;

         mpram_rdw_wmerge #(
            .DATAW (DATAW),
            .BYTEW (BYTEW),
            .NWP   (nWPORTS),
            .ADDRW (ADDRW)
         ) u_bypass (
            .old_word (old_word),
            .wenb     (wenb_g),
            .wbe      (WBe),
            .waddr    (WAddr),
            .wdata    (WData),
            .addr     (ra),
            .new_word (merged),
            .hit      (unused_hit),
            .loss     (unused_loss)
         );

         // An out-of-range write address may match an out-of-range read
         assign rd_word[r] = in_range ? merged : '0;
      end else begin : g_nobyp
         assign rd_word[r] = old_word;
      end
   end

   logic [nRPORTS-1:0][DATAW-1:0] rdata1_q;
   logic [nRPORTS-1:0]            rvalid1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata1_q  <= '0;
         rvalid1_q <= '0;
      end else begin
         rvalid1_q <= renb_g;
         for (int r = 0; r < nRPORTS; r++) begin
            if (renb_g[r]) rdata1_q[r] <= rd_word[r];
         end
      end
   end

   if (OREG != 0) begin : g_oreg
      logic [nRPORTS-1:0][DATAW-1:0] rdata2_q;
      logic [nRPORTS-1:0]            rvalid2_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata2_q  <= '0;
            rvalid2_q <= '0;
         end else begin
            rvalid2_q <= rvalid1_q;
            for (int r = 0; r < nRPORTS; r++) begin
               if (rvalid1_q[r]) rdata2_q[r] <= rdata1_q[r];
            end
         end
      end

      assign RData  = rdata2_q;
      assign RValid = rvalid2_q;
   end else begin : g_noreg
      assign RData  = rdata1_q;
      assign RValid = rvalid1_q;
   end

endmodule
